convertidor_bcd_binario_seq: RTL and testbench

Sequential packed-BCD to binary converter, the inverse of the binary-to-BCD block on the RTC data path. It takes BCD register values read back from the RTC (seconds, minutes, hours, date) and converts them to binary for the counters and comparators.
- Conversion is iterative (Horner: acc = acc*10 + digit), one digit per clock, MSD first.
- start/busy/done handshake.
- Flags both illegal digits and out-of-range results.

---
 rtl/convertidor_bcd_binario_seq_if.sv | 24 ++
 rtl/convertidor_bcd_binario_seq.sv | 114 +++++++++++
 tb/tb_convertidor_bcd_binario_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/convertidor_bcd_binario_seq_if.sv
// Handshake and data bundle for the sequential packed-BCD to binary converter.
// The master drives start/bcd_in; the slave (converter) returns status and result.
interface convertidor_bcd_binario_seq_if #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 8
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err_digit;
    logic                  err_range;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, err_digit, err_range
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, err_digit, err_range
    );
endinterface

// File: rtl/convertidor_bcd_binario_seq.sv
// Iterative packed-BCD to binary converter: one digit per clock, MSD first,
// acc = acc*10 + digit, with illegal-digit and out-of-range flags held with the result.
module convertidor_bcd_binario_seq #(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned BIN_W   = 8,
    parameter int unsigned MAX_VAL = 99
) (
    input  logic                        clk,
    input  logic                        rst_n,
    convertidor_bcd_binario_seq_if.slave bus
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StConv = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    sh_q, sh_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bad_q, bad_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic            err_digit_q, err_digit_d;
    logic            err_range_q, err_range_d;

    logic [3:0]      digit;
    logic [W-1:0]    acc_next;
    logic [31:0]     acc_w;
    logic            over;

    assign digit    = sh_q[W-1 -: 4];
    // 4*DIGITS bits always holds acc*10+d, even with illegal nibbles folded in.
    assign acc_next = (acc_q << 3) + (acc_q << 1) + W'(digit);
    assign acc_w    = 32'(acc_q);
    assign over     = (acc_w > MAX_VAL) || ((acc_w >> BIN_W) != 32'd0);

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bad_d       = bad_q;
        busy_d      = busy_q;
        done_d      = done_q;
        bin_d       = bin_q;
        err_digit_d = err_digit_q;
        err_range_d = err_range_q;
        case (state_q)
            StIdle: begin
                done_d = 1'b0;
                if (bus.start) begin
                    sh_d    = bus.bcd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    bad_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StConv;
                end
            end
            StConv: begin
                if (digit > 4'd9) bad_d = 1'b1;
                acc_d = acc_next;
                sh_d  = sh_q << 4;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(DIGITS - 1)) state_d = StDone;
            end
            StDone: begin
                state_d     = StIdle;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                bin_d       = (bad_q || over) ? '0 : BIN_W'(acc_q);
                err_digit_d = bad_q;
                err_range_d = !bad_q && over;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sh_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            bad_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bin_q       <= '0;
            err_digit_q <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bin_q       <= bin_d;
            err_digit_q <= err_digit_d;
            err_range_q <= err_range_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bin_out   = bin_q;
    assign bus.err_digit = err_digit_q;
    assign bus.err_range = err_range_q;
endmodule

// File: tb/tb_convertidor_bcd_binario_seq.sv
// Bench for convertidor_bcd_binario_seq: three configurations checked every cycle against
// a latency/arithmetic reference model, plus directed literal checks.
module tb_convertidor_bcd_binario_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic        start_v [3];
    logic [11:0] bcd_v   [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic [7:0]  bin_a   [3];
    logic        ed_a    [3];
    logic        er_a    [3];

    convertidor_bcd_binario_seq_if #(.DIGITS(2), .BIN_W(8)) if0 ();
    convertidor_bcd_binario_seq_if #(.DIGITS(2), .BIN_W(8)) if1 ();
    convertidor_bcd_binario_seq_if #(.DIGITS(3), .BIN_W(8)) if2 ();

    convertidor_bcd_binario_seq #(.DIGITS(2), .BIN_W(8), .MAX_VAL(99))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    convertidor_bcd_binario_seq #(.DIGITS(2), .BIN_W(8), .MAX_VAL(23))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    convertidor_bcd_binario_seq #(.DIGITS(3), .BIN_W(8), .MAX_VAL(255))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    assign if0.start = start_v[0];
    assign if0.bcd_in = bcd_v[0][7:0];
    assign if1.start = start_v[1];
    assign if1.bcd_in = bcd_v[1][7:0];
    assign if2.start = start_v[2];
    assign if2.bcd_in = bcd_v[2];

    assign busy_a[0] = if0.busy;  assign done_a[0] = if0.done;  assign bin_a[0] = if0.bin_out;
    assign ed_a[0] = if0.err_digit;  assign er_a[0] = if0.err_range;
    assign busy_a[1] = if1.busy;  assign done_a[1] = if1.done;  assign bin_a[1] = if1.bin_out;
    assign ed_a[1] = if1.err_digit;  assign er_a[1] = if1.err_range;
    assign busy_a[2] = if2.busy;  assign done_a[2] = if2.done;  assign bin_a[2] = if2.bin_out;
    assign ed_a[2] = if2.err_digit;  assign er_a[2] = if2.err_range;

    function automatic int dig_of(input int i);
        return (i == 2) ? 3 : 2;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? 99 : ((i == 1) ? 23 : 255);
    endfunction

    function automatic int bcd_value(input logic [11:0] b, input int nd);
        int v = 0;
        int w = 1;
        for (int j = 0; j < nd; j++) begin
            v += int'((b >> (4 * j)) & 12'hF) * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic bit bcd_bad(input logic [11:0] b, input int nd);
        bit r = 1'b0;
        for (int j = 0; j < nd; j++) if (((b >> (4 * j)) & 12'hF) > 12'd9) r = 1'b1;
        return r;
    endfunction

    function automatic logic [11:0] rand_bcd();
        logic [11:0] r;
        for (int j = 0; j < 3; j++) begin
            if ($urandom_range(0, 7) == 0) r[4*j +: 4] = 4'($urandom_range(0, 15));
            else r[4*j +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    function automatic void chk(input string nm, input int act, input int exp);
        n_asrt++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: count cycles since acceptance; result appears DIGITS+1 edges later.
    int unsigned ph    [3] = '{0, 0, 0};
    int          p_val [3] = '{0, 0, 0};
    bit          p_bad [3] = '{0, 0, 0};
    logic        m_busy[3] = '{0, 0, 0};
    logic        m_done[3] = '{0, 0, 0};
    logic [7:0]  m_bin [3] = '{0, 0, 0};
    logic        m_ed  [3] = '{0, 0, 0};
    logic        m_er  [3] = '{0, 0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                ph[i] <= 0;  m_busy[i] <= 0;  m_done[i] <= 0;
                m_bin[i] <= 0;  m_ed[i] <= 0;  m_er[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ph[i] == 0) begin
                    m_done[i] <= 1'b0;
                    if (start_v[i]) begin
                        ph[i]     <= 1;
                        m_busy[i] <= 1'b1;
                        p_val[i]  <= bcd_value(bcd_v[i], dig_of(i));
                        p_bad[i]  <= bcd_bad(bcd_v[i], dig_of(i));
                    end
                end else if (ph[i] < dig_of(i) + 1) begin
                    ph[i] <= ph[i] + 1;
                end else begin
                    ph[i]     <= 0;
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                    if (p_bad[i]) begin
                        m_bin[i] <= 0;  m_ed[i] <= 1;  m_er[i] <= 0;
                    end else if (p_val[i] > max_of(i) || p_val[i] > 255) begin
                        m_bin[i] <= 0;  m_ed[i] <= 0;  m_er[i] <= 1;
                    end else begin
                        m_bin[i] <= 8'(p_val[i]);  m_ed[i] <= 0;  m_er[i] <= 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy[%0d]", i), int'(busy_a[i]), int'(m_busy[i]));
                chk($sformatf("done[%0d]", i), int'(done_a[i]), int'(m_done[i]));
                chk($sformatf("bin_out[%0d]", i), int'(bin_a[i]), int'(m_bin[i]));
                chk($sformatf("err_digit[%0d]", i), int'(ed_a[i]), int'(m_ed[i]));
                chk($sformatf("err_range[%0d]", i), int'(er_a[i]), int'(m_er[i]));
            end
        end
    end

    // Called at a negedge; start is seen at the next edge k, result checked after k+DIGITS+1.
    task automatic run_lit(input int i, input logic [11:0] b, input int eb, input int eed,
                           input int eer);
        start_v[i] = 1'b1;
        bcd_v[i]   = b;
        @(negedge clk);
        start_v[i] = 1'b0;
        bcd_v[i]   = 12'hFFF;
        for (int c = 1; c <= dig_of(i); c++) begin
            @(negedge clk);
            chk($sformatf("lit busy[%0d] %h c%0d", i, b, c), int'(busy_a[i]), 1);
            chk($sformatf("lit done[%0d] %h c%0d", i, b, c), int'(done_a[i]), 0);
        end
        @(negedge clk);
        chk($sformatf("lit done[%0d] %h", i, b), int'(done_a[i]), 1);
        chk($sformatf("lit busy end[%0d] %h", i, b), int'(busy_a[i]), 0);
        chk($sformatf("lit bin[%0d] %h", i, b), int'(bin_a[i]), eb);
        chk($sformatf("lit err_digit[%0d] %h", i, b), int'(ed_a[i]), eed);
        chk($sformatf("lit err_range[%0d] %h", i, b), int'(er_a[i]), eer);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            bcd_v[i]   = '0;
        end
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset bin[%0d]", i), int'(bin_a[i]), 0);
            chk($sformatf("reset busy[%0d]", i), int'(busy_a[i]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_lit(0, 12'h059, 59, 0, 0);
        run_lit(0, 12'h000, 0, 0, 0);
        run_lit(0, 12'h099, 99, 0, 0);  // back-to-back with the previous start
        run_lit(0, 12'h05A, 0, 1, 0);
        run_lit(0, 12'h007, 7, 0, 0);
        run_lit(1, 12'h023, 23, 0, 0);
        run_lit(1, 12'h024, 0, 0, 1);
        run_lit(2, 12'h255, 255, 0, 0);
        run_lit(2, 12'h256, 0, 0, 1);
        run_lit(2, 12'h9F0, 0, 1, 0);

        // start held high with new data while busy: single result from the first operand
        start_v[0] = 1'b1;  bcd_v[0] = 12'h012;
        @(negedge clk);
        bcd_v[0] = 12'h045;
        @(negedge clk);
        chk("hold done k+1", int'(done_a[0]), 0);
        @(negedge clk);
        chk("hold done k+2", int'(done_a[0]), 0);
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("hold done k+3", int'(done_a[0]), 1);
        chk("hold bin", int'(bin_a[0]), 12);
        @(negedge clk);
        chk("hold single done", int'(done_a[0]), 0);

        // reset during conversion aborts it
        start_v[0] = 1'b1;  bcd_v[0] = 12'h033;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy_a[0]), 0);
        chk("abort bin", int'(bin_a[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort no done", int'(done_a[0]), 0);
        end
        run_lit(0, 12'h042, 42, 0, 0);

        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                start_v[i] = ($urandom_range(0, 3) == 0);
                bcd_v[i]   = rand_bcd();
            end
            if (cyc == 300) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        repeat (6) @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
